vga_ellipse_multi: RTL and testbench

- Parametrised successor to the single fixed-ellipse VGA image generator.
- Renders up to N_CH filled ellipses, each with runtime-programmable centre, radii, colour and enable, over a programmable background.
- Sits between the VGA timing controller (pix_x/pix_y/frame_start) and the RGB565 output driver.
- Config is double-buffered, so each frame is drawn from a consistent parameter set.

---
 rtl/vga_ellipse_multi.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_vga_ellipse_multi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ellipse_multi.sv
// +--------------------------------------------------------------------------+
// | vga_ellipse_multi: N_CH filled ellipses over a background, RGB565 out.    |
// | Optional motion of channel 0: define VGA_ELLIPSE_BOUNCE_EN.               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_ellipse_multi #(
   parameter int          N_CH        = 4,
   parameter int          H_ACT       = 640,
   parameter int          V_ACT       = 480,
   parameter logic [15:0] BG_COLOR    = 16'h0000,
   parameter int          BOUNCE_STEP = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        frame_start,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_ch,
   input  logic [2:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   output logic [15:0] pix_data,
   output logic        busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SQ     = 2'd1;
   localparam logic [1:0] ST_PROD   = 2'd2;
   localparam logic [1:0] ST_COMMIT = 2'd3;

   generate
      if (N_CH < 1 || N_CH > 8 || H_ACT < 1 || H_ACT > 1023 || V_ACT < 1 || V_ACT > 1023 ||
          BOUNCE_STEP < 0 || BOUNCE_STEP >= H_ACT) begin : g_bad_params
         $error("vga_ellipse_multi: parameter out of range");
      end
   endgenerate

   // shadow (cfg-visible), staging (being precomputed) and active (drawing) sets
   logic [9:0]      sh_cx_q [N_CH], sh_cx_d [N_CH], sh_cy_q [N_CH], sh_cy_d [N_CH];
   logic [9:0]      sh_rx_q [N_CH], sh_rx_d [N_CH], sh_ry_q [N_CH], sh_ry_d [N_CH];
   logic [15:0]     sh_col_q[N_CH], sh_col_d[N_CH];
   logic [N_CH-1:0] sh_en_q, sh_en_d;

   logic [9:0]      stg_cx_q [N_CH], stg_cx_d [N_CH], stg_cy_q [N_CH], stg_cy_d [N_CH];
   logic [9:0]      stg_rx_q [N_CH], stg_rx_d [N_CH], stg_ry_q [N_CH], stg_ry_d [N_CH];
   logic [15:0]     stg_col_q[N_CH], stg_col_d[N_CH];
   logic [N_CH-1:0] stg_en_q, stg_en_d;
   logic [19:0]     stg_rx2_q[N_CH], stg_rx2_d[N_CH], stg_ry2_q[N_CH], stg_ry2_d[N_CH];
   logic [39:0]     stg_rxy2_q[N_CH], stg_rxy2_d[N_CH];

   logic [9:0]      act_cx_q [N_CH], act_cx_d [N_CH], act_cy_q [N_CH], act_cy_d [N_CH];
   logic [9:0]      act_rx_q [N_CH], act_rx_d [N_CH], act_ry_q [N_CH], act_ry_d [N_CH];
   logic [15:0]     act_col_q[N_CH], act_col_d[N_CH];
   logic [N_CH-1:0] act_en_q, act_en_d;
   logic [19:0]     act_rx2_q[N_CH], act_rx2_d[N_CH], act_ry2_q[N_CH], act_ry2_d[N_CH];
   logic [39:0]     act_rxy2_q[N_CH], act_rxy2_d[N_CH];

   logic [1:0]  state_q, state_d;
   logic [2:0]  ch_idx_q, ch_idx_d;
   logic        busy_q, busy_d;
   logic        is_commit;

   logic [9:0]  sel_rx, sel_ry;
   logic [19:0] sel_rx2, sel_ry2;
   logic [19:0] sq_rx, sq_ry;
   logic [39:0] prod_rxy;

   logic [9:0]      dx_q [N_CH], dx_d [N_CH], dy_q [N_CH], dy_d [N_CH];
   logic [19:0]     dx2_q[N_CH], dx2_d[N_CH], dy2_q[N_CH], dy2_d[N_CH];
   logic [40:0]     lhs  [N_CH];
   logic [N_CH-1:0] hit_q, hit_d;
   logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [15:0]     pix_q, pix_d;

   assign is_commit = (state_q == ST_COMMIT);

`ifdef VGA_ELLIPSE_BOUNCE_EN
   logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic       rev_x, rev_y, nx, ny;
   logic [9:0] bnc_cx, bnc_cy;

   // Edges are tested at the current position; the step then follows the
   // (possibly reversed) direction.
   always_comb begin
      rev_x   = dir_x_q ? ((11'(stg_cx_q[0]) + 11'(stg_rx_q[0])) > 11'(H_ACT - 1))
                        : (stg_cx_q[0] < stg_rx_q[0]);
      rev_y   = dir_y_q ? ((11'(stg_cy_q[0]) + 11'(stg_ry_q[0])) > 11'(V_ACT - 1))
                        : (stg_cy_q[0] < stg_ry_q[0]);
      nx      = dir_x_q ^ rev_x;
      ny      = dir_y_q ^ rev_y;
      bnc_cx  = nx ? stg_cx_q[0] + 10'(BOUNCE_STEP) : stg_cx_q[0] - 10'(BOUNCE_STEP);
      bnc_cy  = ny ? stg_cy_q[0] + 10'(BOUNCE_STEP) : stg_cy_q[0] - 10'(BOUNCE_STEP);
      dir_x_d = is_commit ? nx : dir_x_q;
      dir_y_d = is_commit ? ny : dir_y_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_x_q <= 1'b1;
         dir_y_q <= 1'b1;
      end else begin
         dir_x_q <= dir_x_d;
         dir_y_q <= dir_y_d;
      end
   end
`endif

   // Shadow registers; a cfg write beats the motion write-back on the same field.
   always_comb begin
      sh_cx_d  = sh_cx_q;
      sh_cy_d  = sh_cy_q;
      sh_rx_d  = sh_rx_q;
      sh_ry_d  = sh_ry_q;
      sh_col_d = sh_col_q;
      sh_en_d  = sh_en_q;
`ifdef VGA_ELLIPSE_BOUNCE_EN
      if (is_commit) begin
         sh_cx_d[0] = bnc_cx;
         sh_cy_d[0] = bnc_cy;
      end
`endif
      for (int k = 0; k < N_CH; k++) begin
         if (cfg_we && cfg_ch == 3'(k)) begin
            case (cfg_addr)
               3'd0:    sh_cx_d[k]  = cfg_wdata[9:0];
               3'd1:    sh_cy_d[k]  = cfg_wdata[9:0];
               3'd2:    sh_rx_d[k]  = cfg_wdata[9:0];
               3'd3:    sh_ry_d[k]  = cfg_wdata[9:0];
               3'd4:    sh_col_d[k] = cfg_wdata;
               3'd5:    sh_en_d[k]  = cfg_wdata[0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      sel_rx  = '0;
      sel_ry  = '0;
      sel_rx2 = '0;
      sel_ry2 = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (ch_idx_q == 3'(k)) begin
            sel_rx  = stg_rx_q[k];
            sel_ry  = stg_ry_q[k];
            sel_rx2 = stg_rx2_q[k];
            sel_ry2 = stg_ry2_q[k];
         end
      end
      sq_rx    = 20'(sel_rx) * 20'(sel_rx);
      sq_ry    = 20'(sel_ry) * 20'(sel_ry);
      prod_rxy = 40'(sel_rx2) * 40'(sel_ry2);
   end

   always_comb begin
      state_d    = state_q;
      ch_idx_d   = ch_idx_q;
      busy_d     = busy_q;
      stg_cx_d   = stg_cx_q;
      stg_cy_d   = stg_cy_q;
      stg_rx_d   = stg_rx_q;
      stg_ry_d   = stg_ry_q;
      stg_col_d  = stg_col_q;
      stg_en_d   = stg_en_q;
      stg_rx2_d  = stg_rx2_q;
      stg_ry2_d  = stg_ry2_q;
      stg_rxy2_d = stg_rxy2_q;
      act_cx_d   = act_cx_q;
      act_cy_d   = act_cy_q;
      act_rx_d   = act_rx_q;
      act_ry_d   = act_ry_q;
      act_col_d  = act_col_q;
      act_en_d   = act_en_q;
      act_rx2_d  = act_rx2_q;
      act_ry2_d  = act_ry2_q;
      act_rxy2_d = act_rxy2_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               stg_cx_d  = sh_cx_d;
               stg_cy_d  = sh_cy_d;
               stg_rx_d  = sh_rx_d;
               stg_ry_d  = sh_ry_d;
               stg_col_d = sh_col_d;
               stg_en_d  = sh_en_d;
               ch_idx_d  = 3'd0;
               busy_d    = 1'b1;
               state_d   = ST_SQ;
            end
         end
         ST_SQ: begin
            for (int k = 0; k < N_CH; k++) begin
               if (ch_idx_q == 3'(k)) begin
                  stg_rx2_d[k] = sq_rx;
                  stg_ry2_d[k] = sq_ry;
               end
            end
            state_d = ST_PROD;
         end
         ST_PROD: begin
            for (int k = 0; k < N_CH; k++) begin
               if (ch_idx_q == 3'(k)) stg_rxy2_d[k] = prod_rxy;
            end
            ch_idx_d = ch_idx_q + 3'd1;
            state_d  = (ch_idx_q == 3'(N_CH - 1)) ? ST_COMMIT : ST_SQ;
         end
         ST_COMMIT: begin
            act_cx_d   = stg_cx_q;
            act_cy_d   = stg_cy_q;
            act_rx_d   = stg_rx_q;
            act_ry_d   = stg_ry_q;
            act_col_d  = stg_col_q;
            act_en_d   = stg_en_q;
            act_rx2_d  = stg_rx2_q;
            act_ry2_d  = stg_ry2_q;
            act_rxy2_d = stg_rxy2_q;
`ifdef VGA_ELLIPSE_BOUNCE_EN
            act_cx_d[0] = bnc_cx;
            act_cy_d[0] = bnc_cy;
`endif
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pixel pipeline: |delta| -> squares -> cross-multiplied compare -> priority select
   always_comb begin
      v1_d = (pix_x != 10'h3ff) && (pix_y != 10'h3ff);
      v2_d = v1_q;
      v3_d = v2_q;
      for (int k = 0; k < N_CH; k++) begin
         dx_d[k]  = (pix_x >= act_cx_q[k]) ? pix_x - act_cx_q[k] : act_cx_q[k] - pix_x;
         dy_d[k]  = (pix_y >= act_cy_q[k]) ? pix_y - act_cy_q[k] : act_cy_q[k] - pix_y;
         dx2_d[k] = 20'(dx_q[k]) * 20'(dx_q[k]);
         dy2_d[k] = 20'(dy_q[k]) * 20'(dy_q[k]);
         lhs[k]   = 41'(dx2_q[k]) * 41'(act_ry2_q[k]) + 41'(dy2_q[k]) * 41'(act_rx2_q[k]);
         hit_d[k] = act_en_q[k] && (act_rx_q[k] != 10'd0) && (act_ry_q[k] != 10'd0) &&
                    (lhs[k] <= 41'(act_rxy2_q[k]));
      end
      pix_d = BG_COLOR;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (hit_q[k]) pix_d = act_col_q[k];
      end
      if (!v3_q) pix_d = 16'h0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_cx_q    <= '{default: '0};
         sh_cy_q    <= '{default: '0};
         sh_rx_q    <= '{default: '0};
         sh_ry_q    <= '{default: '0};
         sh_col_q   <= '{default: '0};
         sh_en_q    <= '0;
         stg_cx_q   <= '{default: '0};
         stg_cy_q   <= '{default: '0};
         stg_rx_q   <= '{default: '0};
         stg_ry_q   <= '{default: '0};
         stg_col_q  <= '{default: '0};
         stg_en_q   <= '0;
         stg_rx2_q  <= '{default: '0};
         stg_ry2_q  <= '{default: '0};
         stg_rxy2_q <= '{default: '0};
         act_cx_q   <= '{default: '0};
         act_cy_q   <= '{default: '0};
         act_rx_q   <= '{default: '0};
         act_ry_q   <= '{default: '0};
         act_col_q  <= '{default: '0};
         act_en_q   <= '0;
         act_rx2_q  <= '{default: '0};
         act_ry2_q  <= '{default: '0};
         act_rxy2_q <= '{default: '0};
         state_q    <= ST_IDLE;
         ch_idx_q   <= 3'd0;
         busy_q     <= 1'b0;
         dx_q       <= '{default: '0};
         dy_q       <= '{default: '0};
         dx2_q      <= '{default: '0};
         dy2_q      <= '{default: '0};
         hit_q      <= '0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         v3_q       <= 1'b0;
         pix_q      <= 16'h0000;
      end else begin
         sh_cx_q    <= sh_cx_d;
         sh_cy_q    <= sh_cy_d;
         sh_rx_q    <= sh_rx_d;
         sh_ry_q    <= sh_ry_d;
         sh_col_q   <= sh_col_d;
         sh_en_q    <= sh_en_d;
         stg_cx_q   <= stg_cx_d;
         stg_cy_q   <= stg_cy_d;
         stg_rx_q   <= stg_rx_d;
         stg_ry_q   <= stg_ry_d;
         stg_col_q  <= stg_col_d;
         stg_en_q   <= stg_en_d;
         stg_rx2_q  <= stg_rx2_d;
         stg_ry2_q  <= stg_ry2_d;
         stg_rxy2_q <= stg_rxy2_d;
         act_cx_q   <= act_cx_d;
         act_cy_q   <= act_cy_d;
         act_rx_q   <= act_rx_d;
         act_ry_q   <= act_ry_d;
         act_col_q  <= act_col_d;
         act_en_q   <= act_en_d;
         act_rx2_q  <= act_rx2_d;
         act_ry2_q  <= act_ry2_d;
         act_rxy2_q <= act_rxy2_d;
         state_q    <= state_d;
         ch_idx_q   <= ch_idx_d;
         busy_q     <= busy_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         dx2_q      <= dx2_d;
         dy2_q      <= dy2_d;
         hit_q      <= hit_d;
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         v3_q       <= v3_d;
         pix_q      <= pix_d;
      end
   end

   assign pix_data = pix_q;
   assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_ellipse_multi.sv
// +--------------------------------------------------------------------------+
// | tb_vga_ellipse_multi: directed self-checking bench for vga_ellipse_multi. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vga_ellipse_multi;

   localparam logic [15:0] BG = 16'h1234;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pix_x, pix_y;
   logic        frame_start;
   logic        cfg_we;
   logic [2:0]  cfg_ch, cfg_addr;
   logic [15:0] cfg_wdata;
   logic [15:0] pix_data;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   vga_ellipse_multi #(
      .N_CH(4), .H_ACT(640), .V_ACT(480), .BG_COLOR(BG), .BOUNCE_STEP(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .pix_data(pix_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // All helpers start and end on a falling edge.
   task automatic run_pixel(input logic [9:0] x, input logic [9:0] y,
                            output logic [15:0] at3, output logic [15:0] at4);
      pix_x = x; pix_y = y;
      @(negedge clk);
      pix_x = 10'h3ff; pix_y = 10'h3ff;
      @(negedge clk);
      @(negedge clk);
      at3 = pix_data;
      @(negedge clk);
      at4 = pix_data;
   endtask

   task automatic cfg_write(input logic [2:0] ch, input logic [2:0] addr, input logic [15:0] d);
      cfg_we = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic cfg_ellipse(input logic [2:0] ch, input int cx, input int cy,
                              input int rx, input int ry, input logic [15:0] col);
      cfg_write(ch, 3'd0, 16'(cx));
      cfg_write(ch, 3'd1, 16'(cy));
      cfg_write(ch, 3'd2, 16'(rx));
      cfg_write(ch, 3'd3, 16'(ry));
      cfg_write(ch, 3'd4, col);
      cfg_write(ch, 3'd5, 16'h0001);
   endtask

   // Pulses frame_start, optionally re-pulses it while busy, counts busy cycles.
   task automatic do_frame(input bit second_pulse, output int cycles);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) cycles++;
         frame_start = second_pulse && (i == 2);
         @(negedge clk);
      end
      frame_start = 1'b0;
   endtask

   task automatic test_reset;
      logic [15:0] a3, a4;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_total++; if (pix_data !== 16'h0000) $display("FAIL reset_pix: got %h want 0000", pix_data); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      run_pixel(10'd10, 10'd10, a3, a4);
      n_total++; if (a4 !== BG) $display("FAIL reset_bg: got %h want %h", a4, BG); else n_pass++;
      run_pixel(10'h3ff, 10'd5, a3, a4);
      n_total++; if (a4 !== 16'h0000) $display("FAIL reset_invalid: got %h want 0000", a4); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy_idle: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_basic;
      logic [15:0] a3, a4;
      int cyc;
      logic [9:0]  px [5];
      logic [9:0]  py [5];
      logic [15:0] ex [5];
      px = '{10'd320, 10'd520, 10'd320, 10'd521, 10'd320};
      py = '{10'd240, 10'd240, 10'd340, 10'd240, 10'd341};
      ex = '{16'hCF59, 16'hCF59, 16'hCF59, BG, BG};
      cfg_ellipse(3'd0, 320, 240, 200, 100, 16'hCF59);
      run_pixel(10'd320, 10'd240, a3, a4);
      n_total++; if (a4 !== BG) $display("FAIL basic_precommit: got %h want %h", a4, BG); else n_pass++;
      do_frame(1'b0, cyc);
      n_total++; if (cyc != 9) $display("FAIL basic_busy_len: got %0d want 9", cyc); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         run_pixel(px[i], py[i], a3, a4);
         n_total++; if (a3 !== 16'h0000) $display("FAIL basic_lat3_%0d: got %h want 0000", i, a3); else n_pass++;
         n_total++; if (a4 !== ex[i]) $display("FAIL basic_pix_%0d: got %h want %h", i, a4, ex[i]); else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0]  px [4];
      logic [15:0] ex [4];
      px = '{10'd520, 10'd521, 10'd120, 10'd320};
      ex = '{16'hCF59, BG, 16'hCF59, 16'hCF59};
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin pix_x = px[i]; pix_y = 10'd240; end
         else begin pix_x = 10'h3ff; pix_y = 10'h3ff; end
         @(negedge clk);
         if (i >= 3 && i < 7) begin
            n_total++;
            if (pix_data !== ex[i-3]) $display("FAIL b2b_pix_%0d: got %h want %h", i-3, pix_data, ex[i-3]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_overlap;
      logic [15:0] a3, a4;
      int cyc;
      cfg_ellipse(3'd1, 100, 100, 20, 20, 16'h07E0);
      cfg_ellipse(3'd2, 105, 100, 30, 30, 16'hF800);
      do_frame(1'b0, cyc);
      run_pixel(10'd100, 10'd100, a3, a4);
      n_total++; if (a4 !== 16'h07E0) $display("FAIL overlap_prio: got %h want 07e0", a4); else n_pass++;
      run_pixel(10'd130, 10'd100, a3, a4);
      n_total++; if (a4 !== 16'hF800) $display("FAIL overlap_ch2: got %h want f800", a4); else n_pass++;
      cfg_write(3'd1, 3'd5, 16'h0000);
      run_pixel(10'd100, 10'd100, a3, a4);
      n_total++; if (a4 !== 16'h07E0) $display("FAIL overlap_shadow: got %h want 07e0", a4); else n_pass++;
      do_frame(1'b0, cyc);
      run_pixel(10'd100, 10'd100, a3, a4);
      n_total++; if (a4 !== 16'hF800) $display("FAIL overlap_disable: got %h want f800", a4); else n_pass++;
   endtask

   task automatic test_shadow;
      logic [15:0] a3, a4;
      int cyc;
      cfg_write(3'd0, 3'd4, 16'h001F);
      cfg_write(3'd6, 3'd4, 16'hFFFF);
      cfg_write(3'd0, 3'd6, 16'h0000);
      cfg_write(3'd0, 3'd7, 16'h0000);
      run_pixel(10'd320, 10'd240, a3, a4);
      n_total++; if (a4 !== 16'hCF59) $display("FAIL shadow_old_color: got %h want cf59", a4); else n_pass++;
      do_frame(1'b0, cyc);
      run_pixel(10'd320, 10'd240, a3, a4);
      n_total++; if (a4 !== 16'h001F) $display("FAIL shadow_new_color: got %h want 001f", a4); else n_pass++;
      run_pixel(10'd520, 10'd240, a3, a4);
      n_total++; if (a4 !== 16'h001F) $display("FAIL shadow_bad_addr: got %h want 001f", a4); else n_pass++;
      run_pixel(10'd130, 10'd100, a3, a4);
      n_total++; if (a4 !== 16'hF800) $display("FAIL shadow_bad_ch: got %h want f800", a4); else n_pass++;
      // write coincident with frame_start joins the snapshot
      cfg_we = 1'b1; cfg_ch = 3'd0; cfg_addr = 3'd4; cfg_wdata = 16'h5555; frame_start = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; frame_start = 1'b0;
      for (int i = 0; i < 40; i++) @(negedge clk);
      run_pixel(10'd320, 10'd240, a3, a4);
      n_total++; if (a4 !== 16'h5555) $display("FAIL shadow_same_cycle: got %h want 5555", a4); else n_pass++;
   endtask

   task automatic test_rx_zero_and_rebusy;
      logic [15:0] a3, a4;
      int cyc;
      cfg_ellipse(3'd3, 500, 400, 0, 10, 16'hFFFF);
      do_frame(1'b1, cyc);
      n_total++; if (cyc != 9) $display("FAIL rebusy_len: got %0d want 9", cyc); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rebusy_idle: got %b want 0", busy); else n_pass++;
      run_pixel(10'd500, 10'd400, a3, a4);
      n_total++; if (a4 !== BG) $display("FAIL rx_zero: got %h want %h", a4, BG); else n_pass++;
   endtask

   task automatic test_reset_midframe;
      logic [15:0] a3, a4;
      pix_x = 10'd320; pix_y = 10'd240;
      for (int i = 0; i < 5; i++) @(negedge clk);
      n_total++; if (pix_data !== 16'h5555) $display("FAIL midrst_pre: got %h want 5555", pix_data); else n_pass++;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (pix_data !== 16'h0000) $display("FAIL midrst_pix: got %h want 0000", pix_data); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      pix_x = 10'h3ff; pix_y = 10'h3ff;
      for (int i = 0; i < 4; i++) @(negedge clk);
      run_pixel(10'd320, 10'd240, a3, a4);
      n_total++; if (a4 !== BG) $display("FAIL midrst_cleared: got %h want %h", a4, BG); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; pix_x = 10'h3ff; pix_y = 10'h3ff; frame_start = 1'b0;
      cfg_we = 1'b0; cfg_ch = 3'd0; cfg_addr = 3'd0; cfg_wdata = 16'h0000;
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_overlap();
      test_shadow();
      test_rx_zero_and_rebusy();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
